// File: rtl/dcs_chan_rr_arb.sv
// dcs_chan_rr_arb
//   Packet-level round-robin arbiter. It merges NUM_REQ header-only ECI channels
//   onto one shared channel, for example rsp_wod/fwd_wod from several DCS slices
//   feeding a single CDC FIFO. The output stage is one register, and the
//   arbiter accepts one packet per cycle.
//
//   Optional feature: define DCS_ARB_PERF_EN to build per-requester saturating
//   grant counters. Without it, grant_cnt_o is tied to zero.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   req_hdr_i         packed requester headers, requester i at [i*HDR_WIDTH +: HDR_WIDTH]
//   req_pkt_size_i    packed requester sizes, same packing
//   req_pkt_vc_i      packed requester VCs, same packing
//   req_pkt_valid_i   requester valid
//   req_pkt_ready_o   requester ready (one-hot or zero)
//   out_hdr_o         merged header
//   out_pkt_size_o    merged size
//   out_pkt_vc_o      merged VC
//   out_pkt_valid_o   merged valid
//   out_pkt_ready_i   downstream ready
//   out_src_o         index of the requester that sourced the current output
//   grant_cnt_o       per-requester accept counters (DCS_ARB_PERF_EN only)
module dcs_chan_rr_arb #(
  parameter int NUM_REQ         = 2,
  parameter int HDR_WIDTH       = 64,
  parameter int SIZE_WIDTH      = 5,
  parameter int VC_WIDTH        = 4,
  parameter int PERF_REGS_WIDTH = 32,
  localparam int SRC_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ*HDR_WIDTH-1:0]       req_hdr_i,
  input  logic [NUM_REQ*SIZE_WIDTH-1:0]      req_pkt_size_i,
  input  logic [NUM_REQ*VC_WIDTH-1:0]        req_pkt_vc_i,
  input  logic [NUM_REQ-1:0]                 req_pkt_valid_i,
  output logic [NUM_REQ-1:0]                 req_pkt_ready_o,
  output logic [HDR_WIDTH-1:0]               out_hdr_o,
  output logic [SIZE_WIDTH-1:0]              out_pkt_size_o,
  output logic [VC_WIDTH-1:0]                out_pkt_vc_o,
  output logic                               out_pkt_valid_o,
  input  logic                               out_pkt_ready_i,
  output logic [SRC_W-1:0]                   out_src_o,
  output logic [NUM_REQ*PERF_REGS_WIDTH-1:0] grant_cnt_o
);

  logic                  valid_q, valid_d;
  logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [VC_WIDTH-1:0]   vc_q, vc_d;
  logic [SRC_W-1:0]      src_q, src_d;
  logic [SRC_W-1:0]      ptr_q, ptr_d;

  logic                  load;
  logic                  accept;
  logic                  win_found;
  logic [SRC_W-1:0]      win_idx;
  logic [HDR_WIDTH-1:0]  sel_hdr;
  logic [SIZE_WIDTH-1:0] sel_size;
  logic [VC_WIDTH-1:0]   sel_vc;

  // The output register can take a new packet when it is empty or being drained.
  assign load   = !valid_q || out_pkt_ready_i;
  assign accept = load && win_found;

  // Scan ptr+1, ptr+2, ... ptr (mod NUM_REQ). The first valid requester wins.
  always_comb begin
    logic [SRC_W-1:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = SRC_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req_pkt_valid_i[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    sel_hdr  = '0;
    sel_size = '0;
    sel_vc   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == SRC_W'(i)) begin
        sel_hdr  = req_hdr_i[i*HDR_WIDTH +: HDR_WIDTH];
        sel_size = req_pkt_size_i[i*SIZE_WIDTH +: SIZE_WIDTH];
        sel_vc   = req_pkt_vc_i[i*VC_WIDTH +: VC_WIDTH];
      end
    end
  end

  always_comb begin
    req_pkt_ready_o = '0;
    if (accept) req_pkt_ready_o[win_idx] = 1'b1;
  end

  // The fields are held while stalled. Priority rotates only when a packet is accepted.
  always_comb begin
    valid_d = valid_q;
    hdr_d   = hdr_q;
    size_d  = size_q;
    vc_d    = vc_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (load) valid_d = win_found;
    if (accept) begin
      hdr_d  = sel_hdr;
      size_d = sel_size;
      vc_d   = sel_vc;
      src_d  = win_idx;
      ptr_d  = win_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      hdr_q   <= '0;
      size_q  <= '0;
      vc_q    <= '0;
      src_q   <= '0;
      ptr_q   <= SRC_W'(NUM_REQ - 1);
    end else begin
      valid_q <= valid_d;
      hdr_q   <= hdr_d;
      size_q  <= size_d;
      vc_q    <= vc_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_pkt_valid_o = valid_q;
  assign out_hdr_o       = hdr_q;
  assign out_pkt_size_o  = size_q;
  assign out_pkt_vc_o    = vc_q;
  assign out_src_o       = src_q;

`ifdef DCS_ARB_PERF_EN
  logic [PERF_REGS_WIDTH-1:0] cnt_q [NUM_REQ];

  // The counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && (win_idx == SRC_W'(i)) && (cnt_q[i] != '1))
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++)
      grant_cnt_o[i*PERF_REGS_WIDTH +: PERF_REGS_WIDTH] = cnt_q[i];
  end
`else
  assign grant_cnt_o = '0;
`endif

endmodule
